pic_ack_controller: RTL and testbench

Synchronous interrupt-acknowledge and in-service controller for the 8259A-compatible PIC. It takes the masked request vector and arbitrates it under fully nested, rotatable priority. It sequences the two-pulse INTA handshake, maintains the In-Service Register and the rotation pointer, and executes OCW2 EOI/rotate commands. It sits between the IRR/IMR datapath and the CPU-facing bus/control logic.

---
 rtl/pic_ack_controller_if.sv | 34 +++
 rtl/pic_ack_controller.sv | 215 +++++++++++++++++++++
 tb/tb_pic_ack_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pic_ack_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_ack_controller_if
// Description : Bus bundle between the 8259A-style acknowledge controller and
//               its surrounding IRR/IMR datapath and CPU-facing logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_ack_controller_if;
    logic [7:0] irr_masked;
    logic       inta_pulse;
    logic       ocw2_wr;
    logic [7:0] ocw2;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;
    logic [2:0] lowest_prio;

    // Surrounding logic: drives requests/commands, observes the controller
    modport master (
        output irr_masked, inta_pulse, ocw2_wr, ocw2, aeoi, vector_base,
        input  int_out, isr, irr_clear, data_out, data_oe, lowest_prio
    );

    // Acknowledge controller side
    modport slave (
        input  irr_masked, inta_pulse, ocw2_wr, ocw2, aeoi, vector_base,
        output int_out, isr, irr_clear, data_out, data_oe, lowest_prio
    );
endinterface
`default_nettype wire

// File: rtl/pic_ack_controller.sv
`default_nettype none
// ============================================================================
// Module      : pic_ack_controller
// Description : Interrupt-acknowledge / in-service controller for an
//               8259A-compatible PIC. Fully nested rotatable priority, two-pulse
//               INTA sequencing, ISR maintenance and OCW2 EOI/rotate commands.
//               Optional macro PIC_ROTATION_EN enables priority rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_ack_controller (
    input  wire                 clk,
    input  wire                 reset,
    pic_ack_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK1 = 2'd1,
        S_ACK2 = 2'd2
    } state_t;

    // Returns {found, level} of the highest-priority set bit; priority runs
    // upward from lp+1, so the loop walks lowest to highest and keeps the last hit.
    function automatic logic [3:0] f_pick(input logic [7:0] vec, input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            lvl = lp + 3'(i);
            if (vec[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    function automatic logic [7:0] f_onehot(input logic [2:0] lvl);
        return 8'b0000_0001 << lvl;
    endfunction

    state_t     r_state, w_state_nxt;
    logic       r_int_out, w_int_nxt;
    logic [7:0] r_isr, w_isr_nxt;
    logic [7:0] r_irr_clear, w_irr_clear_nxt;
    logic [7:0] r_data_out, w_data_out_nxt;
    logic       r_data_oe, w_data_oe_nxt;
    logic [2:0] r_ack_level, w_ack_level_nxt;
    logic       r_ack_spurious, w_ack_spurious_nxt;
    logic [7:0] w_isr_set, w_aeoi_clr, w_eoi_clr;
    logic [2:0] w_lp;
    logic [3:0] w_req_pick, w_isr_pick;
    logic       w_req_found, w_isr_found, w_qual;
    logic [2:0] w_req_lvl, w_isr_lvl, w_req_rank, w_isr_rank;
    logic [2:0] w_cmd, w_ocw_l;
    wire        w_unused_ocw2 = &{1'b0, bus.ocw2[4:3]};

`ifdef PIC_ROTATION_EN
    logic [2:0] r_lowest_prio, w_lp_nxt, w_ocw_lp;
    logic       r_rot_aeoi, w_rot_aeoi_nxt, w_ocw_lp_wr, w_aeoi_rot;
    assign w_lp = r_lowest_prio;
`else
    assign w_lp = 3'd7;
`endif

    assign w_cmd   = bus.ocw2[7:5];
    assign w_ocw_l = bus.ocw2[2:0];

    // Arbitration: best pending request must outrank the best in-service level
    assign w_req_pick  = f_pick(bus.irr_masked, w_lp);
    assign w_isr_pick  = f_pick(r_isr, w_lp);
    assign w_req_found = w_req_pick[3];
    assign w_req_lvl   = w_req_pick[2:0];
    assign w_isr_found = w_isr_pick[3];
    assign w_isr_lvl   = w_isr_pick[2:0];
    assign w_req_rank  = w_req_lvl - w_lp - 3'd1;
    assign w_isr_rank  = w_isr_lvl - w_lp - 3'd1;
    assign w_qual      = w_req_found && (!w_isr_found || (w_req_rank < w_isr_rank));

    // INTA sequencing: next state and acknowledge-side effects
    always_comb begin
        w_state_nxt        = r_state;
        w_int_nxt          = r_int_out;
        w_isr_set          = 8'h00;
        w_aeoi_clr         = 8'h00;
        w_irr_clear_nxt    = 8'h00;
        w_data_out_nxt     = r_data_out;
        w_data_oe_nxt      = 1'b0;
        w_ack_level_nxt    = r_ack_level;
        w_ack_spurious_nxt = r_ack_spurious;
`ifdef PIC_ROTATION_EN
        w_aeoi_rot         = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_qual) begin
                    w_state_nxt = S_ACK1;
                    w_int_nxt   = 1'b1;
                end
            end
            S_ACK1: begin
                if (bus.inta_pulse) begin
                    w_state_nxt = S_ACK2;
                    w_int_nxt   = 1'b0;
                    if (w_qual) begin
                        w_ack_level_nxt    = w_req_lvl;
                        w_ack_spurious_nxt = 1'b0;
                        w_isr_set          = f_onehot(w_req_lvl);
                        w_irr_clear_nxt    = f_onehot(w_req_lvl);
                    end else begin
                        // Request vanished before the ack: report IR7 vector
                        w_ack_level_nxt    = 3'd7;
                        w_ack_spurious_nxt = 1'b1;
                    end
                end
            end
            S_ACK2: begin
                if (bus.inta_pulse) begin
                    w_state_nxt    = S_IDLE;
                    w_data_out_nxt = {bus.vector_base, r_ack_level};
                    w_data_oe_nxt  = 1'b1;
                    if (bus.aeoi && !r_ack_spurious) begin
                        w_aeoi_clr = f_onehot(r_ack_level);
`ifdef PIC_ROTATION_EN
                        w_aeoi_rot = r_rot_aeoi;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // OCW2 decode against pre-edge ISR and priority pointer
    always_comb begin
        w_eoi_clr      = 8'h00;
`ifdef PIC_ROTATION_EN
        w_ocw_lp_wr    = 1'b0;
        w_ocw_lp       = r_lowest_prio;
        w_rot_aeoi_nxt = r_rot_aeoi;
`endif
        if (bus.ocw2_wr) begin
            case (w_cmd)
                3'b001: if (w_isr_found) w_eoi_clr = f_onehot(w_isr_lvl);
                3'b011: w_eoi_clr = f_onehot(w_ocw_l);
`ifdef PIC_ROTATION_EN
                3'b101: begin
                    if (w_isr_found) begin
                        w_eoi_clr   = f_onehot(w_isr_lvl);
                        w_ocw_lp_wr = 1'b1;
                        w_ocw_lp    = w_isr_lvl;
                    end
                end
                3'b111: begin
                    w_eoi_clr   = f_onehot(w_ocw_l);
                    w_ocw_lp_wr = 1'b1;
                    w_ocw_lp    = w_ocw_l;
                end
                3'b110: begin
                    w_ocw_lp_wr = 1'b1;
                    w_ocw_lp    = w_ocw_l;
                end
                3'b100: w_rot_aeoi_nxt = 1'b1;
                3'b000: w_rot_aeoi_nxt = 1'b0;
`else
                3'b101: if (w_isr_found) w_eoi_clr = f_onehot(w_isr_lvl);
                3'b111: w_eoi_clr = f_onehot(w_ocw_l);
`endif
                default: ;
            endcase
        end
    end

    // ISR set takes precedence over any clear of the same bit on one edge
    assign w_isr_nxt = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_isr_set;
`ifdef PIC_ROTATION_EN
    // An OCW2 rotation overrides a simultaneous AEOI rotation
    assign w_lp_nxt = w_ocw_lp_wr ? w_ocw_lp : (w_aeoi_rot ? r_ack_level : r_lowest_prio);
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_int_out      <= 1'b0;
            r_isr          <= 8'h00;
            r_irr_clear    <= 8'h00;
            r_data_out     <= 8'h00;
            r_data_oe      <= 1'b0;
            r_ack_level    <= 3'd7;
            r_ack_spurious <= 1'b0;
`ifdef PIC_ROTATION_EN
            r_lowest_prio  <= 3'd7;
            r_rot_aeoi     <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_int_out      <= w_int_nxt;
            r_isr          <= w_isr_nxt;
            r_irr_clear    <= w_irr_clear_nxt;
            r_data_out     <= w_data_out_nxt;
            r_data_oe      <= w_data_oe_nxt;
            r_ack_level    <= w_ack_level_nxt;
            r_ack_spurious <= w_ack_spurious_nxt;
`ifdef PIC_ROTATION_EN
            r_lowest_prio  <= w_lp_nxt;
            r_rot_aeoi     <= w_rot_aeoi_nxt;
`endif
        end
    end

    assign bus.int_out     = r_int_out;
    assign bus.isr         = r_isr;
    assign bus.irr_clear   = r_irr_clear;
    assign bus.data_out    = r_data_out;
    assign bus.data_oe     = r_data_oe;
    assign bus.lowest_prio = w_lp;
endmodule
`default_nettype wire

// File: tb/tb_pic_ack_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_ack_controller
// Description : Directed, table-driven self-checking bench for
//               pic_ack_controller (default and PIC_ROTATION_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_ack_controller;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

`ifdef PIC_ROTATION_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    pic_ack_controller_if bus_if ();
    pic_ack_controller dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irr;
        logic       inta;
        logic       wr;
        logic [7:0] ocw2;
        logic       aeoi;
        logic [4:0] vb;
        logic       e_int;
        logic [7:0] e_isr;
        logic [7:0] e_clr;
        logic       e_oe;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] irr, input logic inta, input logic wr,
                                input logic [7:0] ocw2, input logic aeoi, input logic [4:0] vb,
                                input logic e_int, input logic [7:0] e_isr, input logic [7:0] e_clr,
                                input logic e_oe, input logic [7:0] e_dout);
        vec_t v;
        v.irr = irr; v.inta = inta; v.wr = wr; v.ocw2 = ocw2; v.aeoi = aeoi; v.vb = vb;
        v.e_int = e_int; v.e_isr = e_isr; v.e_clr = e_clr; v.e_oe = e_oe; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] irr, input logic inta, input logic wr,
                         input logic [7:0] ocw2, input logic aeoi, input logic [4:0] vb);
        bus_if.irr_masked  = irr;
        bus_if.inta_pulse  = inta;
        bus_if.ocw2_wr     = wr;
        bus_if.ocw2        = ocw2;
        bus_if.aeoi        = aeoi;
        bus_if.vector_base = vb;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_int, input logic [7:0] e_isr,
                           input logic [7:0] e_clr, input logic e_oe, input logic [7:0] e_dout,
                           input logic [2:0] e_lp);
        chk({tag, ".int_out"},   {7'b0, bus_if.int_out},     {7'b0, e_int});
        chk({tag, ".isr"},       bus_if.isr,                  e_isr);
        chk({tag, ".irr_clear"}, bus_if.irr_clear,            e_clr);
        chk({tag, ".data_oe"},   {7'b0, bus_if.data_oe},     {7'b0, e_oe});
        chk({tag, ".lowest"},    {5'b0, bus_if.lowest_prio}, {5'b0, e_lp});
        if (e_oe) chk({tag, ".data_out"}, bus_if.data_out, e_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // irr, inta, wr, ocw2, aeoi, vb | int, isr, clr, oe, dout
        tbl.push_back(mk(8'h28,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h28,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h08,1'b0,8'h00));
        tbl.push_back(mk(8'h20,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h20,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b1,8'h83));
        tbl.push_back(mk(8'h20,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h80,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h80,1'b0,1'b1,8'h20,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h80,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h80,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h80,8'h80,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h80,8'h00,1'b1,8'h87));
        tbl.push_back(mk(8'h00,1'b0,1'b1,8'h20,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h04,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b0,5'h1F, 1'b0,8'h00,8'h00,1'b1,8'hFF));
        tbl.push_back(mk(8'h08,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h08,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h08,1'b0,8'h00));
        tbl.push_back(mk(8'h02,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b1,8'h83));
        tbl.push_back(mk(8'h02,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h08,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h02,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h0A,8'h02,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h0A,8'h00,1'b1,8'h81));
        tbl.push_back(mk(8'h00,1'b0,1'b1,8'h20,1'b0,5'h10, 1'b0,8'h08,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b0,1'b1,8'h63,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h10,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h10,1'b1,1'b1,8'h64,1'b0,5'h10, 1'b0,8'h10,8'h10,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h10,8'h00,1'b1,8'h84));
        tbl.push_back(mk(8'h00,1'b0,1'b1,8'h20,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h40,1'b0,1'b0,8'h00,1'b1,5'h10, 1'b1,8'h00,8'h00,1'b0,8'h00));
        tbl.push_back(mk(8'h40,1'b1,1'b0,8'h00,1'b1,5'h10, 1'b0,8'h40,8'h40,1'b0,8'h00));
        tbl.push_back(mk(8'h00,1'b1,1'b0,8'h00,1'b1,5'h10, 1'b0,8'h00,8'h00,1'b1,8'h86));
        tbl.push_back(mk(8'h00,1'b0,1'b0,8'h00,1'b0,5'h10, 1'b0,8'h00,8'h00,1'b0,8'h00));

        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'h10);
        tick();
        tick();
        chk_all("reset", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);
        chk("reset.data_out", bus_if.data_out, 8'h00);
        reset = 1'b0;

        // Table of single-cycle vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].irr, tbl[i].inta, tbl[i].wr, tbl[i].ocw2, tbl[i].aeoi, tbl[i].vb);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].e_int, tbl[i].e_isr, tbl[i].e_clr,
                    tbl[i].e_oe, tbl[i].e_dout, 3'd7);
        end

        // AEOI with rotate-in-AEOI flag set
        drive(8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 5'h10); tick();
        chk_all("rotflag", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);
        drive(8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("aeoi.req", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);
        drive(8'h04, 1'b1, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("aeoi.ack1", 1'b0, 8'h04, 8'h04, 1'b0, 8'h00, 3'd7);
        drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("aeoi.ack2", 1'b0, 8'h00, 8'h00, 1'b1, 8'h82, ROT ? 3'd2 : 3'd7);
        drive(8'h09, 1'b0, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("rot.req", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, ROT ? 3'd2 : 3'd7);
        drive(8'h09, 1'b1, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("rot.ack1", 1'b0, ROT ? 8'h08 : 8'h01, ROT ? 8'h08 : 8'h01, 1'b0, 8'h00,
                ROT ? 3'd2 : 3'd7);
        drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'h10); tick();
        chk_all("rot.ack2", 1'b0, 8'h00, 8'h00, 1'b1, ROT ? 8'h83 : 8'h80, ROT ? 3'd3 : 3'd7);
        drive(8'h00, 1'b0, 1'b1, 8'hC7, 1'b0, 5'h10); tick();
        chk_all("setprio", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);
        drive(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'h10); tick();
        chk_all("clrflag", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);

        // Specific-EOI-rotate, empty NS-rotate, then reset during ACK2
        drive(8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        drive(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        chk_all("ir5.ack2", 1'b0, 8'h20, 8'h00, 1'b1, 8'h85, 3'd7);
        drive(8'h00, 1'b0, 1'b1, 8'hE5, 1'b0, 5'h10); tick();
        chk_all("seoirot", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ROT ? 3'd5 : 3'd7);
        drive(8'h00, 1'b0, 1'b1, 8'hA0, 1'b0, 5'h10); tick();
        chk_all("nsrot.empty", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ROT ? 3'd5 : 3'd7);
        drive(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        chk_all("ir0.req", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, ROT ? 3'd5 : 3'd7);
        drive(8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        chk_all("ir0.ack1", 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, ROT ? 3'd5 : 3'd7);
        reset = 1'b1;
        drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        chk_all("rst.ack2", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);
        chk("rst.ack2.data_out", bus_if.data_out, 8'h00);
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'h10); tick();
        chk_all("post.rst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
